f1_light_sequencer: RTL
=======================

// Module: f1_light_sequencer
// PURPOSE
//  Master sequencer for the start-light gantry. Drives one external delay timer
//  (trigger/N/time_out) through NUM_LIGHTS fixed steps, lighting one more lamp per step.
//  Then it runs one pseudo-random hold and blanks all lamps ("lights out").
//  Sits between the start button synchroniser and the lamp drivers.
// PARAMETERS
//  WIDTH      14     width of delay_n; must match the delay timer.
//  NUM_LIGHTS 5      number of lamps; range 1..8.
//  STEP_N     500    delay_n used for each lamp step; must be >= 1.
//  RAND_BASE  1000   minimum random-hold delay_n.
//  RAND_BITS  11     LFSR bits added to RAND_BASE; must be <= WIDTH.
// PORTS
//  clk            in   1           system clock; all logic on posedge.
//  rst_n          in   1           asynchronous active-low reset.
//  start          in   1           synchronised start request (level).
//  delay_time_out in   1           one-cycle pulse from the delay timer.
//  delay_trigger  out  1           one-cycle load/start pulse to the delay timer.
//  delay_n        out  WIDTH       count for the delay timer; held stable while busy.
//  lights         out  NUM_LIGHTS  lamp drives in thermometer code; bit0 lights first.
//  busy           out  1           high from sequence accept until lights out.
//  done           out  1           one-cycle pulse in the cycle the lamps blank.
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, idx=0, all outputs 0, lfsr=14'h0001.
//  lfsr: 14-bit Fibonacci, taps 14,13,12,2. Free-runs every cycle, including in IDLE.
//  start: internal rising-edge detect (start & ~start_q); start_q resets to 0.
//  FSM:
//   IDLE: on a start rising edge -> S_TRIG, busy=1, delay_n=STEP_N.
//     A start already high out of reset is not an edge.
//   S_TRIG: delay_trigger=1 for exactly this cycle -> S_WAIT.
//   S_WAIT: on delay_time_out: lights[idx]<=1, idx++ (registered, visible next cycle).
//     If idx was NUM_LIGHTS-1 -> R_TRIG, otherwise -> S_TRIG.
//   R_TRIG: latch delay_n = sat(RAND_BASE + lfsr[RAND_BITS-1:0]).
//     sat: the (WIDTH+1)-bit sum clamps to 2^WIDTH-1; a result of 0 is forced to 1.
//     delay_trigger=1 in this cycle -> R_WAIT.
//   R_WAIT: on delay_time_out -> lights<=0, done<=1 for one cycle, busy<=0, idx<=0, -> IDLE.
//  delay_n is registered and changes only in IDLE->S_TRIG and in R_TRIG.
//  delay_time_out in IDLE/S_TRIG/R_TRIG is ignored (stale pulses are dropped).
//  start edges while busy=1 are ignored; no re-queue.
//  The next sequence may start from the first start edge after done.
//  Reset mid-sequence immediately blanks lights, clears busy, and suppresses done.
//  All outputs are registered (Moore); no combinational path from inputs to outputs.
// CONFIGURATION
//  JUMP_START_DETECT_EN defined: adds input launch (1b) and output fault (1b).
//   A launch high in S_TRIG/S_WAIT/R_TRIG/R_WAIT -> state FAULT.
//   FAULT: lights = all ones, fault=1, busy=0, no delay_trigger, done not asserted.
//   FAULT -> IDLE on the next start rising edge (fault clears, lights clear).
//   Reset value of fault is 0.
//  JUMP_START_DETECT_EN undefined: launch and fault ports do not exist; no FAULT state.
// TESTING
//  T1 NUM_LIGHTS=5, STEP_N=4; start pulse; time_out returned 4 clk after each trigger.
//     -> Five S triggers with delay_n=4; lights 00001,00011,...,11111; then one R trigger.
//  T2 After R trigger, time_out -> next cycle lights=0, done=1 for 1 cycle, busy=0.
//     delay_n equals RAND_BASE + lfsr[10:0] as sampled at R_TRIG.
//  T3 RAND_BASE=16380, WIDTH=14, lfsr[10:0]=0x7FF -> delay_n=16383 (saturated).
//     RAND_BASE=0 with lfsr bits=0 -> delay_n=1.
//  T4 start edges in S_WAIT and R_WAIT, plus time_out injected in IDLE.
//     -> No extra trigger, no lights change, no restart.
//  T5 rst_n low after lamp 3 -> same-cycle lights=0, busy=0.
//     After release, start edge -> sequence restarts at lamp 1.
//  T6 (JUMP_START_DETECT_EN) launch=1 after lamp 2 -> lights=11111, fault=1, no done.
//     Start edge -> IDLE, fault=0.

Source files
------------

// File: rtl/f1_light_sequencer.sv
// Start-light gantry sequencer: NUM_LIGHTS timed lamp steps, one pseudo-random hold, then lights out.
// Optional jump-start detection (launch/fault ports, FAULT state) is built when JUMP_START_DETECT_EN is defined.
//   state  | meaning
//   IDLE   | waiting for a start rising edge
//   S_TRIG | delay timer loaded with STEP_N for the current lamp
//   S_WAIT | waiting for the lamp-step timeout
//   R_TRIG | delay timer loaded with the random hold
//   R_WAIT | waiting for the random-hold timeout
//   FAULT  | jump start seen; all lamps on until the next start edge
module f1_light_sequencer #(
    parameter int WIDTH      = 14,
    parameter int NUM_LIGHTS = 5,
    parameter int STEP_N     = 500,
    parameter int RAND_BASE  = 1000,
    parameter int RAND_BITS  = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  delay_time_out,
`ifdef JUMP_START_DETECT_EN
    input  logic                  launch,
    output logic                  fault,
`endif
    output logic                  delay_trigger,
    output logic [WIDTH-1:0]      delay_n,
    output logic [NUM_LIGHTS-1:0] lights,
    output logic                  busy,
    output logic                  done
);

    localparam int IDX_W = (NUM_LIGHTS > 1) ? $clog2(NUM_LIGHTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LIGHTS - 1);

    typedef enum logic [2:0] {
        IDLE,
        S_TRIG,
        S_WAIT,
        R_TRIG,
        R_WAIT
`ifdef JUMP_START_DETECT_EN
        , FAULT
`endif
    } state_t;

    state_t                  state, state_d;
    logic [IDX_W-1:0]        idx, idx_d;
    logic [NUM_LIGHTS-1:0]   lights_d;
    logic [WIDTH-1:0]        delay_n_d;
    logic                    trig_d, busy_d, done_d;
    logic [13:0]             lfsr;
    logic                    start_q, armed, start_rise;
    logic [WIDTH:0]          rand_sum;
    logic [WIDTH-1:0]        rand_n;
`ifdef JUMP_START_DETECT_EN
    logic                    fault_d;
`endif

    // armed stays low for the first cycle after reset so a start held high through reset is not an edge
    assign start_rise = start & ~start_q & armed;

    assign rand_sum = (WIDTH+1)'(RAND_BASE) + (WIDTH+1)'(lfsr[RAND_BITS-1:0]);
    always_comb begin
        rand_n = rand_sum[WIDTH-1:0];
        if (rand_sum[WIDTH])
            rand_n = '1;
        else if (rand_sum[WIDTH-1:0] == '0)
            rand_n = WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr    <= 14'h0001;
            start_q <= 1'b0;
            armed   <= 1'b0;
        end else begin
            lfsr    <= {lfsr[12:0], lfsr[13] ^ lfsr[12] ^ lfsr[11] ^ lfsr[1]};
            start_q <= start;
            armed   <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            lights        <= '0;
            delay_n       <= '0;
            delay_trigger <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
`ifdef JUMP_START_DETECT_EN
            fault         <= 1'b0;
`endif
        end else begin
            state         <= state_d;
            idx           <= idx_d;
            lights        <= lights_d;
            delay_n       <= delay_n_d;
            delay_trigger <= trig_d;
            busy          <= busy_d;
            done          <= done_d;
`ifdef JUMP_START_DETECT_EN
            fault         <= fault_d;
`endif
        end
    end

    // Outputs are computed one cycle ahead so the trigger and its delay_n appear together in *_TRIG
    always_comb begin
        state_d   = state;
        idx_d     = idx;
        lights_d  = lights;
        delay_n_d = delay_n;
        trig_d    = 1'b0;
        busy_d    = busy;
        done_d    = 1'b0;
`ifdef JUMP_START_DETECT_EN
        fault_d   = fault;
`endif
        case (state)
            IDLE: begin
                if (start_rise) begin
                    state_d   = S_TRIG;
                    trig_d    = 1'b1;
                    busy_d    = 1'b1;
                    delay_n_d = WIDTH'(STEP_N);
                end
            end
            S_TRIG: state_d = S_WAIT;
            S_WAIT: begin
                if (delay_time_out) begin
                    lights_d = (lights << 1) | NUM_LIGHTS'(1);
                    idx_d    = idx + IDX_W'(1);
                    trig_d   = 1'b1;
                    if (idx == LAST_IDX) begin
                        state_d   = R_TRIG;
                        delay_n_d = rand_n;
                    end else begin
                        state_d = S_TRIG;
                    end
                end
            end
            R_TRIG: state_d = R_WAIT;
            R_WAIT: begin
                if (delay_time_out) begin
                    state_d  = IDLE;
                    lights_d = '0;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    idx_d    = '0;
                end
            end
`ifdef JUMP_START_DETECT_EN
            FAULT: begin
                if (start_rise) begin
                    state_d  = IDLE;
                    fault_d  = 1'b0;
                    lights_d = '0;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
`ifdef JUMP_START_DETECT_EN
        if (launch && (state == S_TRIG || state == S_WAIT || state == R_TRIG || state == R_WAIT)) begin
            state_d  = FAULT;
            lights_d = '1;
            fault_d  = 1'b1;
            busy_d   = 1'b0;
            trig_d   = 1'b0;
            done_d   = 1'b0;
            idx_d    = '0;
        end
`endif
    end

endmodule
